// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - sliding 3x3 pixel window generator with two line buffers
// Optional window sum output enabled by defining WINGEN_SUM_EN.
module window_gen_3x3 #(
   parameter int MAX_ROW = 540,
   parameter int MAX_COL = 540
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic [7:0]  data_i,
   input  logic        data_en_i,
   output logic [71:0] win_o,
   output logic        win_en_o,
   output logic [9:0]  win_row_o,
   output logic [9:0]  win_col_o,
   output logic        frame_done_o
`ifdef WINGEN_SUM_EN
   ,
   output logic [11:0] sum_o
`endif
);

   localparam int CW = $clog2(MAX_COL);
   localparam logic [9:0] LAST_ROW = 10'(MAX_ROW - 1);
   localparam logic [9:0] LAST_COL = 10'(MAX_COL - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t      state;
   logic [9:0]  row;
   logic [9:0]  col;
   logic [7:0]  lb0 [MAX_COL];
   logic [7:0]  lb1 [MAX_COL];
   logic [71:0] win_q;
   logic [71:0] win_next;
   logic [CW-1:0] lb_idx;
   logic [7:0]  top;
   logic [7:0]  mid;
   logic        accept;
   logic        last_col;
   logic        last_row;
   logic        win_valid;

   assign accept    = data_en_i & ~clear_i;
   assign lb_idx    = col[CW-1:0];
   assign top       = lb1[lb_idx];
   assign mid       = lb0[lb_idx];
   assign last_col  = (col == LAST_COL);
   assign last_row  = (row == LAST_ROW);
   assign win_valid = accept && (row >= 10'd2) && (col >= 10'd2);

   // Next window: every row shifts one column left, new column enters at c=2
   always_comb begin
      win_next = '0;
      for (int r = 0; r < 3; r++) begin
         win_next[(r*3)*8 +: 8]   = win_q[(r*3+1)*8 +: 8];
         win_next[(r*3+1)*8 +: 8] = win_q[(r*3+2)*8 +: 8];
      end
      win_next[2*8 +: 8] = top;
      win_next[5*8 +: 8] = mid;
      win_next[8*8 +: 8] = data_i;
   end

   // Line buffers: read-before-write, lb1 holds row-2, lb0 holds row-1; not reset
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[lb_idx] <= lb0[lb_idx];
         lb0[lb_idx] <= data_i;
      end
   end

   // Working window shift register, advances on every accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
      end else if (accept) begin
         win_q <= win_next;
      end
   end

   // Frame FSM and raster counters; clear restarts the frame and drops the pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else if (clear_i) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else if (data_en_i) begin
         case (state)
            IDLE:    state <= FILL;
            FILL:    if (row == 10'd2 && col == 10'd0) state <= RUN;
            RUN:     if (last_row && last_col) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (last_col) begin
            col <= '0;
            row <= last_row ? 10'd0 : row + 10'd1;
         end else begin
            col <= col + 10'd1;
         end
      end
   end

   // Registered window outputs, one cycle after the accepted pixel; hold when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_o        <= '0;
         win_en_o     <= 1'b0;
         win_row_o    <= '0;
         win_col_o    <= '0;
         frame_done_o <= 1'b0;
      end else begin
         win_en_o     <= win_valid;
         frame_done_o <= accept && last_row && last_col;
         if (win_valid) begin
            win_o     <= win_next;
            win_row_o <= row - 10'd1;
            win_col_o <= col - 10'd1;
         end
      end
   end

`ifdef WINGEN_SUM_EN
   logic [11:0] sum_next;

   // Sum of the nine elements of the next window
   always_comb begin
      sum_next = '0;
      for (int k = 0; k < 9; k++) begin
         sum_next = sum_next + 12'(win_next[k*8 +: 8]);
      end
   end

   // Sum registered alongside win_o
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_o <= '0;
      end else if (win_valid) begin
         sum_o <= sum_next;
      end
   end
`endif

endmodule
